// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared forwarding-select and pipeline-age encodings
package cpu_pkg;

   localparam logic [1:0] FWD_ARRAY = 2'b00;
   localparam logic [1:0] FWD_E     = 2'b01;
   localparam logic [1:0] FWD_M     = 2'b10;
   localparam logic [1:0] FWD_W     = 2'b11;

   localparam logic [1:0] AGE_E = 2'd1;
   localparam logic [1:0] AGE_M = 2'd2;
   localparam logic [1:0] AGE_W = 2'd3;

   typedef struct packed {
      logic       valid;
      logic [1:0] age;
      logic       load;
   } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-side bundle between decode and the hazard scoreboard
interface hazard_scoreboard_if #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int CW   = 32
);
   logic            dec_valid;
   logic [AW-1:0]   dec_rs;
   logic [AW-1:0]   dec_rt;
   logic            dec_use_rs;
   logic            dec_use_rt;
   logic            dec_wreg;
   logic [AW-1:0]   dec_waddr;
   logic            dec_is_load;
   logic            flush;
   logic            pipe_hold;
   logic            stall;
   logic [1:0]      fwd_a_sel;
   logic [1:0]      fwd_b_sel;
   logic [NREG-1:0] busy_vec;
   logic [CW-1:0]   stall_count;

   modport master (
      output dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt,
             dec_wreg, dec_waddr, dec_is_load, flush, pipe_hold,
      input  stall, fwd_a_sel, fwd_b_sel, busy_vec, stall_count
   );

   modport slave (
      input  dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt,
             dec_wreg, dec_waddr, dec_is_load, flush, pipe_hold,
      output stall, fwd_a_sel, fwd_b_sel, busy_vec, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// rtl/hazard_scoreboard_sb_entry.sv - one register's pending-writer state
module sb_entry
   import cpu_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      issue,
   input  logic      is_load,
   input  logic      advance,
   output sb_entry_t ent
);

   // Issue only fires on advancing cycles, so giving it priority lets a new
   // writer replace an older one that would otherwise age or retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent <= '0;
      end else if (issue) begin
         ent.valid <= 1'b1;
         ent.age   <= AGE_E;
         ent.load  <= is_load;
      end else if (advance && ent.valid) begin
         if (ent.age == AGE_W) begin
            ent <= '0;
         end else begin
            ent.age <= ent.age + 2'd1;
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register scoreboard driving forwarding selects and load-use stall
module hazard_scoreboard
   import cpu_pkg::*;
#(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int CW   = 32
) (
   input logic               clk,
   input logic               rst,
   hazard_scoreboard_if.slave sb
);

   sb_entry_t       ent [NREG];
   sb_entry_t       ent_a;
   sb_entry_t       ent_b;
   logic            haz_a;
   logic            haz_b;
   logic            stall;
   logic            issue;
   logic            advance;
   logic [NREG-1:0] busy;
   logic [CW-1:0]   cnt;

   assign advance = ~sb.pipe_hold;
   assign issue   = sb.dec_valid & sb.dec_wreg & (sb.dec_waddr != '0)
                  & ~stall & ~sb.flush & ~sb.pipe_hold;

   assign ent[0] = '0;

   for (genvar i = 1; i < NREG; i++) begin : g_entry
      sb_entry u_entry (
         .clk     (clk),
         .rst     (rst),
         .issue   (issue && (sb.dec_waddr == AW'(i))),
         .is_load (sb.dec_is_load),
         .advance (advance),
         .ent     (ent[i])
      );
   end

   assign ent_a = ent[sb.dec_rs];
   assign ent_b = ent[sb.dec_rt];

   // A load still in E has no result yet; everything older can be forwarded.
   assign haz_a = sb.dec_use_rs && (sb.dec_rs != '0) && ent_a.valid
                && ent_a.load && (ent_a.age == AGE_E);
   assign haz_b = sb.dec_use_rt && (sb.dec_rt != '0) && ent_b.valid
                && ent_b.load && (ent_b.age == AGE_E);
   assign stall = sb.dec_valid & ~sb.flush & (haz_a | haz_b);

   always_comb begin
      sb.fwd_a_sel = FWD_ARRAY;
      sb.fwd_b_sel = FWD_ARRAY;
      if (sb.dec_use_rs && (sb.dec_rs != '0) && ent_a.valid) begin
         sb.fwd_a_sel = ent_a.age;
      end
      if (sb.dec_use_rt && (sb.dec_rt != '0) && ent_b.valid) begin
         sb.fwd_b_sel = ent_b.age;
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 1; i < NREG; i++) begin
         busy[i] = ent[i].valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (stall && advance && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sb.stall       = stall;
   assign sb.busy_vec    = busy;
   assign sb.stall_count = cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed table-driven bench for hazard_scoreboard
module tb_hazard_scoreboard;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   hazard_scoreboard_if #(.NREG(32), .AW(5), .CW(32)) sb_if ();

   hazard_scoreboard #(.NREG(32), .AW(5), .CW(32)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        urs;
      logic        urt;
      logic        w;
      logic [4:0]  wa;
      logic        ld;
      logic        fl;
      logic        hd;
      logic        e_stall;
      logic [1:0]  e_fa;
      logic [1:0]  e_fb;
      logic [31:0] e_busy;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic w,
                               input logic [4:0] wa, input logic ld, input logic fl,
                               input logic hd, input logic st, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [31:0] busy,
                               input logic [31:0] cnt);
      vec_t r;
      r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.w = w; r.wa = wa;
      r.ld = ld; r.fl = fl; r.hd = hd; r.e_stall = st; r.e_fa = fa; r.e_fb = fb;
      r.e_busy = busy; r.e_cnt = cnt;
      return r;
   endfunction

   function automatic vec_t idle(input logic [31:0] busy, input logic [31:0] cnt);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, busy, cnt);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      sb_if.dec_valid   = x.v;
      sb_if.dec_rs      = x.rs;
      sb_if.dec_rt      = x.rt;
      sb_if.dec_use_rs  = x.urs;
      sb_if.dec_use_rt  = x.urt;
      sb_if.dec_wreg    = x.w;
      sb_if.dec_waddr   = x.wa;
      sb_if.dec_is_load = x.ld;
      sb_if.flush       = x.fl;
      sb_if.pipe_hold   = x.hd;
   endtask

   task automatic check_all(input string tag, input logic st, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [31:0] busy,
                            input logic [31:0] cnt);
      check({tag, " stall"}, 32'(sb_if.stall), 32'(st));
      check({tag, " fwd_a"}, 32'(sb_if.fwd_a_sel), 32'(fa));
      check({tag, " fwd_b"}, 32'(sb_if.fwd_b_sel), 32'(fb));
      check({tag, " busy"}, sb_if.busy_vec, busy);
      check({tag, " count"}, sb_if.stall_count, cnt);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      drive(idle(0, 0));

      // Test 1: ALU r5 then readers at E, W, and after retire
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0));
      vt.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 32'h20, 0));
      vt.push_back(idle(32'h20, 0));
      vt.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 32'h20, 0));
      vt.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0));
      // Test 2: load r8 then rt reader
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0));
      vt.push_back(mk(1, 0, 8, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 32'h100, 0));
      vt.push_back(mk(1, 0, 8, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h100, 1));
      vt.push_back(idle(32'h100, 1));
      vt.push_back(idle(32'h0, 1));
      // Test 3: ALU r3, load r3, reader that also writes r9
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 1));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 32'h8, 1));
      vt.push_back(mk(1, 3, 0, 1, 0, 1, 9, 0, 0, 0, 1, 2'b01, 2'b00, 32'h8, 1));
      vt.push_back(mk(1, 3, 0, 1, 0, 1, 9, 0, 0, 0, 0, 2'b10, 2'b00, 32'h8, 2));
      vt.push_back(idle(32'h208, 2));
      vt.push_back(idle(32'h200, 2));
      vt.push_back(idle(32'h200, 2));
      vt.push_back(idle(32'h0, 2));
      // Test 4: load r8 then flushed dependent that would write r10
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 32'h0, 2));
      vt.push_back(mk(1, 0, 8, 0, 1, 1, 10, 0, 1, 0, 0, 2'b00, 2'b01, 32'h100, 2));
      vt.push_back(idle(32'h100, 2));
      vt.push_back(idle(32'h100, 2));
      // Test 5: r4 held at age 2 for three cycles, hold also blocks r11 issue
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 2));
      vt.push_back(idle(32'h10, 2));
      for (int i = 0; i < 3; i++)
         vt.push_back(mk(1, 4, 0, 1, 0, 1, 11, 0, 0, 1, 0, 2'b10, 2'b00, 32'h10, 2));
      vt.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 32'h10, 2));
      vt.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 32'h10, 2));
      // stall under hold is visible but not counted
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 2'b00, 2'b00, 32'h0, 2));
      vt.push_back(mk(1, 12, 0, 1, 0, 0, 0, 0, 0, 1, 1, 2'b01, 2'b00, 32'h1000, 2));
      vt.push_back(mk(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 32'h1000, 2));
      vt.push_back(mk(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 32'h1000, 3));
      vt.push_back(idle(32'h1000, 3));
      vt.push_back(idle(32'h0, 3));
      // writes to r0 and writes without dec_valid never allocate
      vt.push_back(mk(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 32'h0, 3));
      vt.push_back(idle(32'h0, 3));
      vt.push_back(mk(0, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 3));
      vt.push_back(idle(32'h0, 3));

      #12;
      check_all("reset", 0, 2'b00, 2'b00, 32'h0, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i]);
         @(negedge clk);
         check_all($sformatf("vec%0d", i), vt[i].e_stall, vt[i].e_fa, vt[i].e_fb,
                   vt[i].e_busy, vt[i].e_cnt);
         @(posedge clk);
         #1;
      end

      // Test 6: asynchronous reset in the middle of a load-use stall
      drive(mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 32'h0, 3));
      @(posedge clk);
      #1 drive(mk(1, 0, 8, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 3));
      @(negedge clk);
      check_all("pre_rst", 1, 2'b00, 2'b01, 32'h100, 3);
      #1 rst = 1'b1;
      #1 check_all("mid_rst", 0, 2'b00, 2'b00, 32'h0, 0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 check_all("post_rst", 0, 2'b00, 2'b00, 32'h0, 0);
      drive(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0));
      @(posedge clk);
      #1 drive(mk(1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0));
      @(negedge clk);
      check_all("reissue", 0, 2'b01, 2'b00, 32'h40, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Per-register scoreboard and hazard controller for the 5-stage pipelined CPU. It tracks every in-flight register write from issue (D→E) to write-back, and drives the register-file read path. Its outputs are the forwarding selects for both decode read ports (E, M or W result, or the register array) and a one-cycle load-use stall. It sits beside the register file in decode and replaces ad-hoc address-compare forwarding with age-tracked, youngest-writer-wins selection.

## Interface
- NREG, 32, number of architectural registers; register 0 is never tracked
- AW, 5, register address width
- CW, 32, stall performance counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- dec_valid  in  1  decode stage holds a valid instruction
- dec_rs, dec_rt  in  AW  source register addresses
- dec_use_rs, dec_use_rt  in  1  source is actually read
- dec_wreg  in  1  instruction writes a register
- dec_waddr  in  AW  destination register
- dec_is_load  in  1  result is produced in M, not E
- flush  in  1  kill the decode instruction this cycle (branch redirect)
- pipe_hold  in  1  global freeze (memory wait); no stage advances
- stall  out  1  hold IF/ID and inject a bubble into E
- fwd_a_sel, fwd_b_sel  out  2  00 array, 01 E result, 10 M result, 11 W result
- busy_vec  out  NREG  bit i set when register i has a pending writer
- stall_count  out  CW  saturating count of stall cycles

## Operation
- Per-register entry: valid, age[1:0] (1=E, 2=M, 3=W), load.
- Issue fires when dec_valid & dec_wreg & dec_waddr!=0 & ~stall & ~flush & ~pipe_hold.
  - On issue, entry[dec_waddr] is set to valid=1, age=1, load=dec_is_load.
  - An existing entry for that register is overwritten, so the youngest writer wins.
- Advance occurs on every cycle with ~pipe_hold.
  - Each valid entry with age 1 or 2 increments its age.
  - A valid entry at age 3 is cleared, because it has been written to the array.
  - If an issue to the same register occurs in that cycle, the issue wins.
- Stall rule: stall=1 only when all of the following hold:
  - dec_valid & ~flush.
  - A used source (rs with dec_use_rs, or rt with dec_use_rt) is nonzero.
  - That source's entry is valid with load=1 and age=1.
- Forward select for port a (b is identical with rt):
  - 00 when the source is r0, the entry is invalid, or dec_use_rs=0.
  - Otherwise the select equals the entry's age: 01, 10 or 11.
  - During a stall, the select still reflects state; consumers ignore it.
- A stall inserts a bubble: downstream entries still age and no entry is allocated. After one cycle the load reaches age 2, stall drops, and the select becomes 10.
- pipe_hold freezes all entries and stall_count, and blocks issue. stall remains combinationally valid.
- stall_count increments on each cycle with stall & ~pipe_hold, saturating at all-ones.
- busy_vec[i] = entry[i].valid; bit 0 is always 0.

## Timing
- stall, fwd_*_sel and busy_vec are combinational from current state and decode inputs, with no registered latency.
- Entry state and stall_count update on the rising clk edge.
- An issued instruction appears at age 1 in the cycle after issue, and retires three advancing cycles later.
- A load-use hazard costs exactly 1 stall cycle per load. Back-to-back dependent ALU instructions cost 0 stall cycles.
- flush and stall in the same cycle: flush wins, so stall=0 and there is no issue.
- Reset (asynchronous, any time including mid-stall): all entries are invalid and stall_count=0.
  - stall=0, fwd selects 00 and busy_vec=0 as soon as rst asserts.
- Releasing rst mid-cycle has no effect until the next rising edge.

## Structure
- Shared package cpu_pkg holds the FWD_ARRAY/FWD_E/FWD_M/FWD_W 2-bit constants and the AGE_E/AGE_M/AGE_W encodings; the forwarding muxes in decode use the same constants.
- Sub-module sb_entry holds one register's valid/age/load state and its issue/advance/retire logic, instantiated NREG-1 times with entry 0 tied off.
- Top level contains:
  - Source lookup: two read muxes over the entries.
  - Stall logic.
  - Saturating counter.

## Test plan
- Test 1: ALU writes r5, then next instruction reads r5 as rs.
  - Response: stall=0 and fwd_a_sel=01.
  - Two cycles later, a third reader of r5 gets 11.
  - The fourth cycle gives 00.
- Test 2: load to r8, then next instruction reads r8 as rt.
  - Response: stall=1 for exactly 1 cycle, then fwd_b_sel=10, and stall_count=1.
- Test 3: ALU writes r3, then load writes r3, then a reader of r3.
  - Response: stall=1 (youngest writer is the load at age 1), then select 10.
- Test 4: load to r8 followed by a dependent reader with flush=1.
  - Response: stall=0, busy_vec has only bit 8 set, and no new entry is allocated.
- Test 5: pipe_hold=1 for 3 cycles with r4 at age 2.
  - Response: r4 stays at age 2 (select 10 throughout) and stall_count is unchanged.
- Test 6: writes to r0, and rst asserted mid-stall.
  - Writes to r0 never set busy_vec[0].
  - rst mid-stall forces stall=0, busy_vec=0 and stall_count=0 immediately.
